// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the fetch/data memory arbiter.
package mem_arb_pkg;

  localparam logic OWNER_IF = 1'b0;
  localparam logic OWNER_D  = 1'b1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // lat_cnt is 3 bits wide, so the read latency must fit in 1..7.
  function automatic bit mem_lat_ok(input int lat);
    return (lat >= 1) && (lat <= 7);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Fetch port, data port and memory-macro bus seen by the arbiter.
interface mem_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 16
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_gnt, if_rvalid, if_rdata, d_gnt, d_rvalid, d_rdata,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants that bypassed a waiting fetch.
module arb_starve_ctr #(
  parameter int unsigned MAX = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic full
);
  localparam int unsigned W = $clog2(MAX + 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign full = (cnt_q == W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr)              cnt_d = '0;
    else if (inc && !full) cnt_d = cnt_q + W'(1);
  end

  // NOTE: sequential state is written with <= so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch and data ports; data has
// priority with a starvation guard for fetch, and a pipeline stall output.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = 12,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 3
) (
  input  logic          clk,
  input  logic          rst,
  mem_arbiter_if.slave  bus,
  output logic          stall
);

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT - 1);

  if (!mem_lat_ok(MEM_LAT)) begin : g_bad_mem_lat
    $error("mem_arbiter: MEM_LAT must be in 1..7");
  end

  arb_state_e        state_q, state_d;
  logic [2:0]        lat_q, lat_d;
  logic              owner_q, owner_d;
  logic [DATA_W-1:0] if_rdata_q, d_rdata_q;
  logic [ADDR_W-1:0] addr_sel;

  logic ret_cycle, issue_ok, starve_full;
  logic if_gnt, d_gnt, if_rvalid, d_rvalid;

  assign ret_cycle = (state_q == BUSY) && (lat_q == 3'd0);
  // Grants are gated by reset so nothing reaches the macro while rst is low.
  assign issue_ok  = rst && ((state_q == IDLE) || ret_cycle);
  assign if_gnt    = issue_ok && bus.if_req && (!bus.d_req || starve_full);
  assign d_gnt     = issue_ok && bus.d_req && !(bus.if_req && starve_full);
  assign if_rvalid = ret_cycle && (owner_q == OWNER_IF);
  assign d_rvalid  = ret_cycle && (owner_q == OWNER_D);

  arb_starve_ctr #(.MAX(STARVE_MAX)) u_starve (
    .clk  (clk),
    .rst  (rst),
    .clr  (if_gnt || !bus.if_req),
    .inc  (d_gnt && bus.if_req),
    .full (starve_full)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      lat_q   <= 3'd0;
      owner_q <= OWNER_IF;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      owner_q <= owner_d;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    lat_d   = lat_q;
    owner_d = owner_q;
    if (if_gnt || (d_gnt && !bus.d_we)) begin
      state_d = BUSY;
      lat_d   = LAT_INIT;
      owner_d = d_gnt ? OWNER_D : OWNER_IF;
    end else if (d_gnt || ret_cycle) begin
      state_d = IDLE;
      lat_d   = 3'd0;
    end else if (state_q == BUSY) begin
      lat_d   = lat_q - 3'd1;
    end
  end

  always_comb begin
    addr_sel      = '0;
    if (d_gnt)       addr_sel = bus.d_addr;
    else if (if_gnt) addr_sel = bus.if_addr;

    bus.if_gnt    = if_gnt;
    bus.d_gnt     = d_gnt;
    bus.if_rvalid = if_rvalid;
    bus.d_rvalid  = d_rvalid;
    bus.mem_en    = if_gnt || d_gnt;
    bus.mem_we    = d_gnt && bus.d_we;
    bus.mem_addr  = addr_sel;
    bus.mem_wdata = d_gnt ? bus.d_wdata : '0;
    bus.if_rdata  = if_rvalid ? bus.mem_rdata : if_rdata_q;
    bus.d_rdata   = d_rvalid  ? bus.mem_rdata : d_rdata_q;
    stall         = (bus.if_req && !if_gnt) || (bus.d_req && !d_gnt) ||
                    ((state_q == BUSY) && (lat_q != 3'd0));
  end

  // Read data is shown combinationally on the return cycle and held afterwards.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (if_rvalid) if_rdata_q <= bus.mem_rdata;
      if (d_rvalid)  d_rdata_q  <= bus.mem_rdata;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter at MEM_LAT 2 (main), 1 and 3, each with a
// small memory model of matching latency.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n;
  logic rst3_n;
  logic rst3;
  logic stall1, stall2, stall3;
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  assign rst3 = rst_n & rst3_n;

  mem_arbiter_if #(.ADDR_W(12), .DATA_W(16)) bus1 ();
  mem_arbiter_if #(.ADDR_W(12), .DATA_W(16)) bus2 ();
  mem_arbiter_if #(.ADDR_W(12), .DATA_W(16)) bus3 ();

  mem_arbiter #(.ADDR_W(12), .DATA_W(16), .MEM_LAT(2), .STARVE_MAX(3)) dut2 (
    .clk(clk), .rst(rst_n), .bus(bus2), .stall(stall2));
  mem_arbiter #(.ADDR_W(12), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(3)) dut1 (
    .clk(clk), .rst(rst_n), .bus(bus1), .stall(stall1));
  mem_arbiter #(.ADDR_W(12), .DATA_W(16), .MEM_LAT(3), .STARVE_MAX(3)) dut3 (
    .clk(clk), .rst(rst3),  .bus(bus3), .stall(stall3));

  // Latency-2 memory with real storage; 0x010 holds 0xBEEF.
  logic [15:0] mem2 [0:4095];
  logic [15:0] p2_0, p2_1;
  always @(posedge clk) begin
    if (!rst_n) begin
      mem2[12'h010] <= 16'hBEEF;
      p2_0 <= '0;
      p2_1 <= '0;
    end else begin
      if (bus2.mem_en && bus2.mem_we) mem2[bus2.mem_addr] <= bus2.mem_wdata;
      p2_0 <= (bus2.mem_en && !bus2.mem_we) ? mem2[bus2.mem_addr] : 16'h0;
      p2_1 <= p2_0;
    end
  end
  assign bus2.mem_rdata = p2_1;

  // Latency-1 and latency-3 memories return a tag plus the address.
  logic [15:0] r1, p3_0, p3_1, p3_2;
  always @(posedge clk) begin
    r1   <= bus1.mem_en ? {4'hA, bus1.mem_addr} : 16'h0;
    p3_0 <= bus3.mem_en ? {4'hC, bus3.mem_addr} : 16'h0;
    p3_1 <= p3_0;
    p3_2 <= p3_1;
  end
  assign bus1.mem_rdata = r1;
  assign bus3.mem_rdata = p3_2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus2.if_req  = 1'b1;
    bus2.if_addr = 12'h010;
    @(negedge clk);
    n_cmp++;
    if ({bus2.if_gnt, bus2.d_gnt, bus2.mem_en, bus2.mem_we} !== 4'b0) begin
      n_fail++;
      $display("FAIL reset_strobes: got %b exp 0000",
               {bus2.if_gnt, bus2.d_gnt, bus2.mem_en, bus2.mem_we});
    end
    n_cmp++;
    if ({bus2.if_rvalid, bus2.d_rvalid} !== 2'b0) begin
      n_fail++;
      $display("FAIL reset_rvalid: got %b exp 00", {bus2.if_rvalid, bus2.d_rvalid});
    end
    n_cmp++;
    if ({bus2.if_rdata, bus2.d_rdata, bus2.mem_addr} !== 44'h0) begin
      n_fail++;
      $display("FAIL reset_data: got %h exp 0", {bus2.if_rdata, bus2.d_rdata, bus2.mem_addr});
    end
    bus2.if_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_fetch();
    bus2.if_req  = 1'b1;
    bus2.if_addr = 12'h010;
    @(negedge clk);
    n_cmp++;
    if ({bus2.if_gnt, bus2.mem_en, bus2.mem_we, stall2} !== 4'b1100) begin
      n_fail++;
      $display("FAIL fetch_issue: got %b exp 1100",
               {bus2.if_gnt, bus2.mem_en, bus2.mem_we, stall2});
    end
    n_cmp++;
    if (bus2.mem_addr !== 12'h010) begin
      n_fail++;
      $display("FAIL fetch_addr: got %h exp 010", bus2.mem_addr);
    end
    tick();
    bus2.if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({stall2, bus2.if_gnt, bus2.if_rvalid, bus2.mem_en} !== 4'b1000) begin
      n_fail++;
      $display("FAIL fetch_wait: got %b exp 1000",
               {stall2, bus2.if_gnt, bus2.if_rvalid, bus2.mem_en});
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({bus2.if_rvalid, bus2.d_rvalid, stall2} !== 3'b100) begin
      n_fail++;
      $display("FAIL fetch_return: got %b exp 100", {bus2.if_rvalid, bus2.d_rvalid, stall2});
    end
    n_cmp++;
    if (bus2.if_rdata !== 16'hBEEF) begin
      n_fail++;
      $display("FAIL fetch_rdata: got %h exp beef", bus2.if_rdata);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({bus2.if_rvalid, bus2.if_rdata} !== {1'b0, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL fetch_hold: got %b/%h exp 0/beef", bus2.if_rvalid, bus2.if_rdata);
    end
    tick();
  endtask

  task automatic test_store_load();
    bus2.d_req   = 1'b1;
    bus2.d_we    = 1'b1;
    bus2.d_addr  = 12'h020;
    bus2.d_wdata = 16'h1234;
    @(negedge clk);
    n_cmp++;
    if ({bus2.d_gnt, bus2.mem_en, bus2.mem_we, bus2.if_gnt} !== 4'b1110) begin
      n_fail++;
      $display("FAIL store_issue: got %b exp 1110",
               {bus2.d_gnt, bus2.mem_en, bus2.mem_we, bus2.if_gnt});
    end
    n_cmp++;
    if ({bus2.mem_addr, bus2.mem_wdata} !== {12'h020, 16'h1234}) begin
      n_fail++;
      $display("FAIL store_bus: got %h/%h exp 020/1234", bus2.mem_addr, bus2.mem_wdata);
    end
    tick();
    bus2.d_we    = 1'b0;
    bus2.d_wdata = 16'h0;
    @(negedge clk);
    n_cmp++;
    if ({bus2.d_gnt, bus2.mem_we, bus2.d_rvalid} !== 3'b100) begin
      n_fail++;
      $display("FAIL load_issue: got %b exp 100", {bus2.d_gnt, bus2.mem_we, bus2.d_rvalid});
    end
    tick();
    bus2.d_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({bus2.d_gnt, bus2.d_rvalid, stall2} !== 3'b001) begin
      n_fail++;
      $display("FAIL load_wait: got %b exp 001", {bus2.d_gnt, bus2.d_rvalid, stall2});
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if ({bus2.d_rvalid, bus2.d_rdata} !== {1'b1, 16'h1234}) begin
      n_fail++;
      $display("FAIL load_return: got %b/%h exp 1/1234", bus2.d_rvalid, bus2.d_rdata);
    end
    n_cmp++;
    if ({bus2.if_rvalid, bus2.if_rdata} !== {1'b0, 16'hBEEF}) begin
      n_fail++;
      $display("FAIL nonowner_hold: got %b/%h exp 0/beef", bus2.if_rvalid, bus2.if_rdata);
    end
    tick();
    @(negedge clk);
    n_cmp++;
    if (bus2.d_rvalid !== 1'b0) begin
      n_fail++;
      $display("FAIL load_pulse: got %b exp 0", bus2.d_rvalid);
    end
    tick();
  endtask

  task automatic test_starvation();
    logic [9:0] exp_dg = 10'h115;
    logic [9:0] exp_ig = 10'h040;
    logic [9:0] exp_dr = 10'h054;
    logic [9:0] exp_ir = 10'h100;
    bus2.if_req  = 1'b1;
    bus2.if_addr = 12'h040;
    bus2.d_req   = 1'b1;
    bus2.d_we    = 1'b0;
    bus2.d_addr  = 12'h030;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus2.d_gnt, bus2.if_gnt} !== {exp_dg[i], exp_ig[i]}) begin
        n_fail++;
        $display("FAIL starve_gnt[%0d]: got d=%b if=%b exp d=%b if=%b",
                 i, bus2.d_gnt, bus2.if_gnt, exp_dg[i], exp_ig[i]);
      end
      n_cmp++;
      if ({bus2.d_rvalid, bus2.if_rvalid, stall2} !== {exp_dr[i], exp_ir[i], 1'b1}) begin
        n_fail++;
        $display("FAIL starve_rv[%0d]: got %b exp %b", i,
                 {bus2.d_rvalid, bus2.if_rvalid, stall2}, {exp_dr[i], exp_ir[i], 1'b1});
      end
      tick();
    end
    bus2.if_req = 1'b0;
    bus2.d_req  = 1'b0;
    repeat (3) tick();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      logic       e_gnt = (i < 4);
      logic       e_rv  = (i >= 1) && (i <= 4);
      logic [15:0] e_rd = 16'hA000 | 16'(i - 1);
      if (i < 4) begin
        bus1.if_req  = 1'b1;
        bus1.if_addr = 12'(i);
      end else begin
        bus1.if_req  = 1'b0;
      end
      @(negedge clk);
      n_cmp++;
      if ({bus1.if_gnt, bus1.if_rvalid, stall1} !== {e_gnt, e_rv, 1'b0}) begin
        n_fail++;
        $display("FAIL b2b_ctl[%0d]: got %b exp %b", i,
                 {bus1.if_gnt, bus1.if_rvalid, stall1}, {e_gnt, e_rv, 1'b0});
      end
      if (e_gnt) begin
        n_cmp++;
        if (bus1.mem_addr !== 12'(i)) begin
          n_fail++;
          $display("FAIL b2b_addr[%0d]: got %h exp %h", i, bus1.mem_addr, 12'(i));
        end
      end
      if (e_rv) begin
        n_cmp++;
        if (bus1.if_rdata !== e_rd) begin
          n_fail++;
          $display("FAIL b2b_rdata[%0d]: got %h exp %h", i, bus1.if_rdata, e_rd);
        end
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_read();
    bus3.if_req  = 1'b1;
    bus3.if_addr = 12'h055;
    @(negedge clk);
    n_cmp++;
    if ({bus3.if_gnt, bus3.mem_addr} !== {1'b1, 12'h055}) begin
      n_fail++;
      $display("FAIL mid_issue: got %b/%h exp 1/055", bus3.if_gnt, bus3.mem_addr);
    end
    tick();
    bus3.if_req = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (stall3 !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_stall: got %b exp 1", stall3);
    end
    #1 rst3_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus3.if_gnt, bus3.if_rvalid, bus3.d_gnt, bus3.d_rvalid,
         bus3.mem_en, bus3.mem_we, stall3} !== 7'b0) begin
      n_fail++;
      $display("FAIL mid_rst_ctl: got %b exp 0", {bus3.if_gnt, bus3.if_rvalid,
               bus3.d_gnt, bus3.d_rvalid, bus3.mem_en, bus3.mem_we, stall3});
    end
    n_cmp++;
    if ({bus3.mem_addr, bus3.mem_wdata, bus3.if_rdata, bus3.d_rdata} !== 60'h0) begin
      n_fail++;
      $display("FAIL mid_rst_data: got %h exp 0",
               {bus3.mem_addr, bus3.mem_wdata, bus3.if_rdata, bus3.d_rdata});
    end
    tick();
    rst3_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus3.if_rvalid, bus3.d_rvalid} !== 2'b00) begin
        n_fail++;
        $display("FAIL mid_dropped[%0d]: got %b exp 00", i, {bus3.if_rvalid, bus3.d_rvalid});
      end
      tick();
    end
    for (int i = 0; i < 5; i++) begin
      bus3.d_req  = (i == 0);
      bus3.d_we   = 1'b0;
      bus3.d_addr = 12'h066;
      @(negedge clk);
      n_cmp++;
      if ({bus3.d_gnt, bus3.d_rvalid} !== {1'(i == 0), 1'(i == 3)}) begin
        n_fail++;
        $display("FAIL mid_after[%0d]: got %b exp %b", i,
                 {bus3.d_gnt, bus3.d_rvalid}, {1'(i == 0), 1'(i == 3)});
      end
      if (i == 3) begin
        n_cmp++;
        if (bus3.d_rdata !== 16'hC066) begin
          n_fail++;
          $display("FAIL mid_rdata: got %h exp c066", bus3.d_rdata);
        end
      end
      tick();
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    rst3_n = 1'b1;
    bus1.if_req = 1'b0; bus1.if_addr = '0; bus1.d_req = 1'b0; bus1.d_we = 1'b0;
    bus1.d_addr = '0;   bus1.d_wdata = '0;
    bus2.if_req = 1'b0; bus2.if_addr = '0; bus2.d_req = 1'b0; bus2.d_we = 1'b0;
    bus2.d_addr = '0;   bus2.d_wdata = '0;
    bus3.if_req = 1'b0; bus3.if_addr = '0; bus3.d_req = 1'b0; bus3.d_we = 1'b0;
    bus3.d_addr = '0;   bus3.d_wdata = '0;
    tick();
    test_reset();
    test_fetch();
    test_store_load();
    test_starvation();
    test_back_to_back();
    test_reset_mid_read();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Shares one single-port memory between the pipeline's instruction-fetch port and its data port (load/store). It sits between the fetch/memory stages and the memory macro. Data accesses take priority, with a starvation guard for fetch. It also produces the pipeline stall signal used alongside the hazard input to freeze the PC and pipeline registers.

## Interface
Parameters:
- ADDR_W, 12, address width (matches 12-bit PC)
- DATA_W, 16, memory word width
- MEM_LAT, 2, cycles from read issue to mem_rdata valid; legal range 1..7
- STARVE_MAX, 3, maximum consecutive data grants while a fetch is waiting

Ports:
- clk  in  1  rising-edge clock; the block's only clock
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request (always a read)
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  fetch issued this cycle
- if_rvalid  out  1  if_rdata valid
- if_rdata  out  DATA_W  fetch read data
- d_req  in  1  data request
- d_we  in  1  1 = store, 0 = load
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data access issued this cycle
- d_rvalid  out  1  d_rdata valid (loads only)
- d_rdata  out  DATA_W  load data
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after the read issue
- stall  out  1  a requester is waiting or its read is in flight

## Operation
- States:
  - IDLE: no read in flight.
  - BUSY: read in flight; lat_cnt counts down from MEM_LAT-1; owner bit records fetch or data.
- Issue is possible in IDLE, or in BUSY on the cycle lat_cnt==0 (the return cycle).
- Issue effects:
  - mem_en=1, with the winner's address, we and wdata driven combinationally.
  - The winner's gnt pulses for exactly 1 cycle.
- Arbitration:
  - Data wins, unless starve_cnt==STARVE_MAX and if_req=1; then fetch wins.
  - starve_cnt increments on each data grant while if_req=1 and is not granted.
  - starve_cnt clears on a fetch grant or whenever if_req=0. It saturates at STARVE_MAX.
- Store issue: the memory write completes in the issue cycle. State stays/returns IDLE, and a new issue is allowed the next cycle. No rvalid.
- Read issue: go to BUSY with lat_cnt=MEM_LAT-1.
  - Each cycle, lat_cnt decrements.
  - At lat_cnt==0, mem_rdata is routed to the owner's rdata and the owner's rvalid pulses for 1 cycle.
  - The same cycle may issue the next access; otherwise the block goes to IDLE.
- Non-owner rdata holds its last value. Owner rdata updates only on rvalid.
- Requesters hold req/addr/we/wdata stable until gnt. Dropping req before gnt is legal and withdraws the request.
- stall = (if_req & ~if_gnt) | (d_req & ~d_gnt) | (BUSY & ~(lat_cnt==0)).
- Reset: asynchronous to IDLE.
  - lat_cnt=0, starve_cnt=0, owner=fetch, if_rdata=0, d_rdata=0.
  - All gnt/rvalid/mem_* outputs are 0.
  - An in-flight read is dropped and produces no rvalid after reset release.
- Width rules:
  - lat_cnt is 3 bits.
  - starve_cnt is $clog2(STARVE_MAX+1) bits and saturates.
  - Addresses pass through unmodified, with no wrap logic.

## Timing
- A read issued at cycle T returns rvalid at T+MEM_LAT. Read throughput is one per MEM_LAT cycles.
- A store issued at T allows the next issue at T+1.
- Grants are combinational from state and request, and are never asserted while BUSY with lat_cnt>0.
- MEM_LAT=1: BUSY lasts one cycle, so back-to-back reads issue every cycle.
- Simultaneous if_req and d_req in an issue cycle: exactly one gnt, and the loser's stall stays 1.

## Structure
- Package mem_arb_pkg holds:
  - localparam OWNER_IF=1'b0, OWNER_D=1'b1;
  - the state enum {IDLE, BUSY};
  - the MEM_LAT legality check.
- Sub-module arb_starve_ctr (saturating starvation counter with clear/inc/full) keeps the priority logic readable.
- The rest is one flat module.

## Test plan
- MEM_LAT=2, if_req=1 at addr 0x010, mem returns 0xBEEF -> if_gnt at T0, mem_en=1/mem_addr=0x010 at T0, if_rvalid=1 with if_rdata=0xBEEF at T2, stall=1 at T1 only.
- Store d_addr=0x020, d_wdata=0x1234 -> d_gnt and mem_we=1 for 1 cycle; a load issued from 0x020 at T+1 -> d_rdata=0x1234 at T+3, no spurious d_rvalid for the store.
- if_req and d_req both held, d_we=0, MEM_LAT=2 -> data grants at T0, T2, T4, fetch grant at T6 (STARVE_MAX=3), then data again at T8.
- MEM_LAT=1, 4 back-to-back fetches 0x000..0x003 -> if_gnt every cycle, rvalid every cycle one cycle behind, stall=0 throughout.
- rst=0 asserted mid-read at T1 of MEM_LAT=3 -> all outputs 0 immediately; after release no if_rvalid/d_rvalid appears; next request granted normally in IDLE.
